instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 16, meaning: maximum cycles imem_req may stay unacknowledged before a fetch fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction to decoder; instr[31:26] drives the decoder opcode input.
REQ-010 instr_valid  output  1  instr and pc are valid.
REQ-011 instr_ready  input  1  downstream consumes instr this cycle.
REQ-012 branch  input  1  decoder Branch for the held instr; sampled only on accept.
REQ-013 zero  input  1  ALU zero flag for the held instr; sampled only on accept.
REQ-014 jump  input  1  decoder Jump for the held instr; sampled only on accept.
REQ-015 pc  output  32  address of the held or in-flight instruction.
REQ-016 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-017 fetch_err  output  1  sticky fault flag.
REQ-018 instr_count  output  32  number of accepted instructions, wraps modulo 2^32.

Function
REQ-019 The block SHALL implement the FSM states IDLE, REQ, HOLD and ERR.
REQ-020 IDLE SHALL move to REQ unconditionally on the first clock edge after reset release.
REQ-021 In REQ, the block SHALL hold imem_req=1 with imem_addr=pc stable until imem_ack.
REQ-022 When imem_ack=1 in REQ, the block SHALL capture imem_rdata into instr, set instr_valid=1 next cycle and enter HOLD; a same-cycle ack gives one-cycle latency.
REQ-023 In any state other than REQ, the block SHALL keep imem_req=0 and ignore imem_ack.
REQ-024 In HOLD, instr, pc and instr_valid=1 SHALL remain stable until instr_ready=1.
REQ-025 Accept is defined as HOLD & instr_ready.
REQ-026 On accept, the next pc SHALL be selected as follows:
- jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
- else branch&zero=1: pc_plus4 + (sign-extended instr[15:0] << 2).
- else: pc_plus4.
REQ-027 Jump SHALL take priority over branch when both are set.
REQ-028 On accept, the block SHALL increment instr_count, clear instr_valid and enter REQ next cycle; peak throughput is one instruction per 2 cycles.
REQ-029 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-030 If the wait counter reaches MAX_WAIT, the block SHALL enter ERR.
REQ-031 If a computed next pc has pc[1:0]≠0, the block SHALL enter ERR instead of REQ and load pc with that address.
REQ-032 In ERR, the block SHALL hold fetch_err=1, imem_req=0 and instr_valid=0 until reset; no other exit exists.
REQ-033 All address arithmetic SHALL be 32-bit, with carry discarded (0xFFFF_FFFC + 4 = 0).

Reset
REQ-034 Asserting rst_n=0 SHALL immediately force the reset values regardless of state, including mid-request or mid-hold:
- state=IDLE, pc=RESET_PC.
- imem_req=0, instr=0, instr_valid=0.
- fetch_err=0, instr_count=0, wait counter=0.
REQ-035 An imem_ack arriving while rst_n=0 SHALL be discarded.
REQ-036 Fetch SHALL restart at RESET_PC.

Verification
REQ-037 Reset release with imem_ack tied 1 and instr_ready tied 1 -> imem_addr sequence 0x0, 0x4, 0x8; requests on every other cycle; instr_count increments by 1 per accept.
REQ-038 pc=0x10, instr=0x1000_FFFE (beq, imm16=-2), branch=1, zero=1 -> next imem_addr=0x0C; same case with zero=0 -> next imem_addr=0x14.
REQ-039 pc=0x4000_0000, instr=0x0800_0040, jump=1, branch=1, zero=1 -> next imem_addr=0x4000_0100 (jump wins).
REQ-040 imem_ack held 0 for MAX_WAIT cycles -> fetch_err=1 and imem_req=0 thereafter; rst_n pulse -> fetch_err=0 and fetch resumes at RESET_PC.
REQ-041 instr_ready held 0 for 5 cycles in HOLD -> instr and pc unchanged and no imem_req; rst_n=0 asserted mid-HOLD -> instr_valid=0 with no clock edge required.
REQ-042 RESET_PC=0x2 -> first accept computes a misaligned next pc -> ERR with fetch_err=1.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetcher with a holding register, branch/jump pc update and a sticky fetch fault.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] next_pc;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign imem_req    = state_q == REQ;
    assign instr_valid = state_q == HOLD;
    assign fetch_err   = state_q == ERR;

    always_comb begin
        next_pc = jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00}
                : (branch & zero) ? pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00}
                : pc_plus4;
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        wait_d  = '0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end else begin
                    wait_d  = wait_q + 32'd1;
                    state_d = (wait_d == MAX_WAIT) ? ERR : REQ;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    pc_d    = next_pc;
                    // a misaligned target still lands in pc so the faulting address is visible
                    state_d = (next_pc[1:0] != 2'b00) ? ERR : REQ;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

endmodule
